// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns one response per command, aborting transfers the slave never completes.
module apb_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_count;
    logic            w_timeoutHit;
    logic            w_done;
    logic            w_accept;

    // An ACCESS cycle ends either because the slave is ready or the wait budget is spent
    assign w_timeoutHit = (TIMEOUT != 0) && (r_count == LAST_WAIT);
    assign w_done       = (r_state == ACCESS) && (PREADY || w_timeoutHit);
    assign cmd_ready    = !PRESET && ((r_state == IDLE) || w_done);
    assign w_accept     = cmd_valid && cmd_ready;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = SETUP;
            SETUP:   w_nextState = ACCESS;
            ACCESS:  if (w_done) w_nextState = w_accept ? SETUP : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        case (r_state)
            SETUP:   PSELx = 1'b1;
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    // Transfer attributes only move on accept, so they hold through SETUP/ACCESS and idle
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            r_count   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
            end
            if (r_state == SETUP) begin
                r_count <= '0;
            end else if ((r_state == ACCESS) && !PREADY && !w_timeoutHit && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
            rsp_valid <= w_done;
            rsp_err   <= w_done && !PREADY;
            rsp_rdata <= (w_done && PREADY && !PWRITE) ? PRDATA : '0;
        end
    end

endmodule
